// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Packets are kept whole by locking the grant until a byte flagged 'last' is sent.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]        req_last_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      uart_start_o,
    output logic [DATA_W-1:0]         uart_data_o,
    input  logic                      uart_rdy_tx_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      busy_o,
    output logic                      err_o,
    input  logic                      err_clr_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ACK_TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_LOW  = 2'd2,
        ST_WAIT_HIGH = 2'd3
    } state_e;

    function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (idx == IDX_LAST) begin
            nxt = {IDX_W{1'b0}};
        end else begin
            nxt = idx + IDX_W'(1'b1);
        end
        return nxt;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec      = {NUM_REQ{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic                lock_q, lock_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic [IDX_W-1:0]    rr_win_s;
    logic [IDX_W-1:0]    scan_idx_s;
    logic                rr_found_s;
    logic [IDX_W-1:0]    win_s;
    logic                cand_ok_s;
    logic [DATA_W-1:0]   win_data_s;
    logic                win_last_s;
    logic                accept_s;
    logic                timeout_s;
    logic [CNT_W-1:0]    cnt_inc_s;
    logic [NUM_REQ-1:0]  req_ready_s;

    // Round-robin search starting at the pointer, wrapping past the top requester.
    always_comb begin
        rr_found_s = 1'b0;
        rr_win_s   = ptr_q;
        scan_idx_s = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rr_found_s && req_valid_i[scan_idx_s]) begin
                rr_found_s = 1'b1;
                rr_win_s   = scan_idx_s;
            end else begin
                rr_found_s = rr_found_s;
            end
            scan_idx_s = idx_next(scan_idx_s);
        end
    end

    // While locked only the owner may send, even if it has nothing to offer.
    always_comb begin
        if (lock_q) begin
            win_s     = owner_q;
            cand_ok_s = req_valid_i[owner_q];
        end else begin
            win_s     = rr_win_s;
            cand_ok_s = rr_found_s;
        end
    end

    // Select the winning requester's byte and last flag.
    always_comb begin
        win_data_s = {DATA_W{1'b0}};
        win_last_s = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (win_s == IDX_W'(r)) begin
                win_data_s = req_data_i[r*DATA_W +: DATA_W];
                win_last_s = req_last_i[r];
            end else begin
                win_data_s = win_data_s;
                win_last_s = win_last_s;
            end
        end
    end

    // Acceptance needs an idle UART; reset also masks the combinational ready.
    assign accept_s  = (state_q == ST_IDLE) && uart_rdy_tx_i && cand_ok_s && rst_i;
    assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_W'(1'b1));

    // Next-state logic: acceptance, start pulse, handshake tracking and timeout.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        lock_d      = lock_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        data_d      = data_q;
        start_d     = 1'b0;
        timeout_s   = 1'b0;
        req_ready_s = {NUM_REQ{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    req_ready_s = onehot(win_s);
                    data_d      = win_data_s;
                    grant_d     = onehot(win_s);
                    owner_d     = win_s;
                    start_d     = 1'b1;
                    state_d     = ST_START;
                    if (win_last_s) begin
                        lock_d = 1'b0;
                        ptr_d  = idx_next(win_s);
                    end else begin
                        lock_d = 1'b1;
                        ptr_d  = ptr_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!uart_rdy_tx_i) begin
                    state_d = ST_WAIT_HIGH;
                end else begin
                    cnt_d = cnt_inc_s;
                    // UART never acknowledged: drop the byte and move past the owner.
                    if (cnt_inc_s == CNT_MAX) begin
                        timeout_s = 1'b1;
                        lock_d    = 1'b0;
                        ptr_d     = idx_next(owner_q);
                        grant_d   = {NUM_REQ{1'b0}};
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_LOW;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (uart_rdy_tx_i) begin
                    state_d = ST_IDLE;
                    if (lock_q) begin
                        grant_d = grant_q;
                    end else begin
                        grant_d = {NUM_REQ{1'b0}};
                    end
                end else begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_d = ST_IDLE;
                lock_d  = 1'b0;
                grant_d = {NUM_REQ{1'b0}};
            end
        endcase

        if (timeout_s) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= {IDX_W{1'b0}};
            owner_q <= {IDX_W{1'b0}};
            lock_q  <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            grant_q <= {NUM_REQ{1'b0}};
            data_q  <= {DATA_W{1'b0}};
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign req_ready_o  = req_ready_s;
    assign uart_start_o = start_q;
    assign uart_data_o  = data_q;
    assign grant_o      = grant_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a small UART model, and a
// transaction-level reference checked against the DUT every cycle.
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int ACK = 15;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NR-1:0]     req_valid_i;
    logic [NR*DW-1:0]  req_data_i;
    logic [NR-1:0]     req_last_i;
    logic [NR-1:0]     req_ready_o;
    logic              uart_start_o;
    logic [DW-1:0]     uart_data_o;
    logic              uart_rdy_tx_i;
    logic [NR-1:0]     grant_o;
    logic              busy_o;
    logic              err_o;
    logic              err_clr_i;

    always #5 clk_i = ~clk_i;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ACK_TIMEOUT(ACK)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
        .req_ready_o(req_ready_o), .uart_start_o(uart_start_o), .uart_data_o(uart_data_o),
        .uart_rdy_tx_i(uart_rdy_tx_i), .grant_o(grant_o), .busy_o(busy_o),
        .err_o(err_o), .err_clr_i(err_clr_i)
    );

    int total = 0;
    int bad   = 0;

    // reference: phase 0 idle, 1 start, 2 awaiting ack-low, 3 awaiting ready-high
    int         m_phase;
    int         m_wl;
    int         m_ptr;
    int         m_owner;
    bit         m_locked;
    bit         m_has_owner;
    bit         m_err;
    logic [7:0] m_data;

    logic [8:0] src_q [NR][$];
    logic [7:0] start_data [$];
    int         uart_mode;
    int         frame;
    int         ucnt;
    logic       st_snap;
    logic [3:0] rr_snap;
    logic [3:0] grant_snap;
    bit         acc_flag;
    int         n_starts;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_cycle();
        int         w;
        bit         set_err;
        logic [3:0] exp_rr;
        logic [3:0] exp_g;
        if (!rst_i) begin
            m_phase = 0; m_wl = 0; m_ptr = 0; m_owner = 0;
            m_locked = 1'b0; m_has_owner = 1'b0; m_err = 1'b0; m_data = 8'h00;
        end
        w = -1;
        if (rst_i && m_phase == 0 && uart_rdy_tx_i) begin
            if (m_locked) begin
                if (req_valid_i[m_owner]) w = m_owner;
            end else begin
                for (int k = 0; k < NR; k++)
                    if (w < 0 && req_valid_i[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
            end
        end
        exp_rr = 4'b0000;
        if (w >= 0) exp_rr[w] = 1'b1;
        exp_g = 4'b0000;
        if (m_has_owner) exp_g[m_owner] = 1'b1;
        chk("cyc_ready", 32'(req_ready_o), 32'(exp_rr));
        chk("cyc_start", 32'(uart_start_o), 32'(m_phase == 1));
        chk("cyc_busy",  32'(busy_o), 32'(m_phase != 0));
        chk("cyc_data",  32'(uart_data_o), 32'(m_data));
        chk("cyc_grant", 32'(grant_o), 32'(exp_g));
        chk("cyc_err",   32'(err_o), 32'(m_err));

        rr_snap    = req_ready_o;
        grant_snap = grant_o;
        st_snap    = uart_start_o;
        if (req_ready_o != 4'b0000) acc_flag = 1'b1;
        if (uart_start_o) begin
            n_starts++;
            start_data.push_back(uart_data_o);
        end
        if (!rst_i) return;

        set_err = 1'b0;
        case (m_phase)
            0: if (w >= 0) begin
                m_data = req_data_i[w*DW +: DW];
                m_owner = w; m_has_owner = 1'b1; m_phase = 1;
                if (req_last_i[w]) begin
                    m_locked = 1'b0; m_ptr = (w + 1) % NR;
                end else begin
                    m_locked = 1'b1;
                end
            end
            1: begin m_phase = 2; m_wl = 0; end
            2: if (!uart_rdy_tx_i) begin
                m_phase = 3;
            end else begin
                m_wl++;
                if (m_wl == ACK) begin
                    set_err = 1'b1; m_locked = 1'b0; m_ptr = (m_owner + 1) % NR;
                    m_has_owner = 1'b0; m_phase = 0;
                end
            end
            default: if (uart_rdy_tx_i) begin
                m_phase = 0;
                if (!m_locked) m_has_owner = 1'b0;
            end
        endcase
        if (set_err) m_err = 1'b1;
        else if (err_clr_i) m_err = 1'b0;
    endtask

    task automatic drive_src();
        for (int r = 0; r < NR; r++) begin
            if (src_q[r].size() > 0) begin
                req_valid_i[r] = 1'b1;
                req_data_i[r*DW +: DW] = src_q[r][0][7:0];
                req_last_i[r] = src_q[r][0][8];
            end else begin
                req_valid_i[r] = 1'b0;
                req_data_i[r*DW +: DW] = 8'h00;
                req_last_i[r] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        model_cycle();
        @(posedge clk_i);
        #1;
        for (int r = 0; r < NR; r++)
            if (rr_snap[r] && src_q[r].size() > 0) void'(src_q[r].pop_front());
        if (uart_mode == 0) begin
            if (st_snap) begin
                uart_rdy_tx_i = 1'b0;
                ucnt = frame;
            end else if (ucnt > 0) begin
                ucnt--;
                if (ucnt == 0) uart_rdy_tx_i = 1'b1;
            end
        end else if (ucnt == 0) begin
            uart_rdy_tx_i = 1'b1;
        end
        drive_src();
    endtask

    function automatic int pending();
        int n = 0;
        for (int r = 0; r < NR; r++) n += src_q[r].size();
        return n;
    endfunction

    task automatic wait_accept(input string nm, input logic [3:0] exp_rr);
        int n = 0;
        acc_flag = 1'b0;
        while (!acc_flag && n < 60) begin
            tick();
            n++;
        end
        chk({nm, "_seen"}, 32'(acc_flag), 32'd1);
        chk(nm, 32'(rr_snap), 32'(exp_rr));
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((busy_o || pending() != 0) && n < 300) begin
            tick();
            n++;
        end
        chk(nm, 32'(busy_o), 32'd0);
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
    endtask

    initial begin
        int         n;
        int         s0;
        logic [7:0] exp2 [5];
        rst_i = 1'b0; req_valid_i = 4'b0000; req_data_i = 32'h0; req_last_i = 4'b0000;
        uart_rdy_tx_i = 1'b1; err_clr_i = 1'b0;
        uart_mode = 0; frame = 6; ucnt = 0; n_starts = 0; acc_flag = 1'b0;
        rr_snap = 4'b0000; grant_snap = 4'b0000; st_snap = 1'b0;
        tick();
        tick();
        chk("rst_start", 32'(uart_start_o), 32'd0);
        chk("rst_busy",  32'(busy_o), 32'd0);
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_err",   32'(err_o), 32'd0);
        chk("rst_data",  32'(uart_data_o), 32'd0);
        rst_i = 1'b1;
        tick();

        // single requester, long UART frame
        frame = 20;
        src_q[0].push_back({1'b1, 8'hA5});
        drive_src();
        wait_accept("t1_ready", 4'b0001);
        chk("t1_start", 32'(uart_start_o), 32'd1);
        chk("t1_data",  32'(uart_data_o), 32'h0000_00A5);
        chk("t1_grant", 32'(grant_o), 32'd1);
        wait_idle("t1_idle");
        chk("t1_rdy_back", 32'(uart_rdy_tx_i), 32'd1);
        chk("t1_grant_clr", 32'(grant_o), 32'd0);
        src_q[0].push_back({1'b1, 8'h11});
        src_q[1].push_back({1'b1, 8'h22});
        drive_src();
        wait_accept("t1_ptr_is_1", 4'b0010);
        wait_idle("t1_idle2");
        frame = 6;

        // all four requesters, single-byte packets
        do_reset();
        src_q[0].push_back({1'b1, 8'h10});
        src_q[0].push_back({1'b1, 8'h14});
        src_q[1].push_back({1'b1, 8'h11});
        src_q[2].push_back({1'b1, 8'h12});
        src_q[3].push_back({1'b1, 8'h13});
        drive_src();
        s0 = n_starts;
        start_data.delete();
        wait_accept("t2_g0", 4'b0001);
        wait_accept("t2_g1", 4'b0010);
        wait_accept("t2_g2", 4'b0100);
        wait_accept("t2_g3", 4'b1000);
        wait_accept("t2_g4", 4'b0001);
        wait_idle("t2_idle");
        chk("t2_starts", 32'(n_starts - s0), 32'd5);
        exp2 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        chk("t2_nbytes", 32'(start_data.size()), 32'd5);
        for (int i = 0; i < 5 && i < start_data.size(); i++)
            chk("t2_byte", 32'(start_data[i]), 32'(exp2[i]));

        // locked 3-byte packet from r1 while r2 waits
        src_q[1].push_back({1'b0, 8'h31});
        src_q[1].push_back({1'b0, 8'h32});
        src_q[1].push_back({1'b1, 8'h33});
        src_q[2].push_back({1'b1, 8'h40});
        drive_src();
        wait_accept("t3_a", 4'b0010);
        wait_accept("t3_b", 4'b0010);
        chk("t3_grant_held_b", 32'(grant_snap), 32'd2);
        wait_accept("t3_c", 4'b0010);
        chk("t3_grant_held_c", 32'(grant_snap), 32'd2);
        wait_accept("t3_d", 4'b0100);
        chk("t3_unlocked", 32'(grant_snap), 32'd0);
        wait_idle("t3_idle");

        // UART never acknowledges: timeout, lock dropped, next requester served
        uart_mode = 1;
        src_q[3].push_back({1'b0, 8'h5A});
        src_q[3].push_back({1'b1, 8'h5B});
        src_q[0].push_back({1'b1, 8'h60});
        drive_src();
        wait_accept("t4_acc", 4'b1000);
        n = 0;
        while (!err_o && n < 40) begin
            tick();
            n++;
        end
        chk("t4_to_cycles", 32'(n), 32'd16);
        chk("t4_busy", 32'(busy_o), 32'd0);
        chk("t4_grant", 32'(grant_o), 32'd0);
        uart_mode = 0;
        wait_accept("t4_next", 4'b0001);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("t4_err_clr", 32'(err_o), 32'd0);
        wait_idle("t4_idle");

        // clear asserted through the timeout cycle: set wins
        uart_mode = 1;
        src_q[1].push_back({1'b1, 8'h77});
        drive_src();
        wait_accept("t5_acc", 4'b0010);
        err_clr_i = 1'b1;
        repeat (16) tick();
        err_clr_i = 1'b0;
        chk("t5_set_wins", 32'(err_o), 32'd1);
        tick();
        chk("t5_sticky", 32'(err_o), 32'd1);
        uart_mode = 0;
        wait_idle("t5_idle");

        // reset while waiting for the UART to finish
        frame = 20;
        src_q[2].push_back({1'b1, 8'h99});
        drive_src();
        wait_accept("t6_acc", 4'b0100);
        repeat (4) tick();
        chk("t6_busy_pre", 32'(busy_o), 32'd1);
        chk("t6_rdy_low", 32'(uart_rdy_tx_i), 32'd0);
        rst_i = 1'b0;
        #1;
        chk("t6_rst_start", 32'(uart_start_o), 32'd0);
        chk("t6_rst_busy",  32'(busy_o), 32'd0);
        chk("t6_rst_grant", 32'(grant_o), 32'd0);
        chk("t6_rst_err",   32'(err_o), 32'd0);
        chk("t6_rst_data",  32'(uart_data_o), 32'd0);
        src_q[3].push_back({1'b1, 8'hC3});
        drive_src();
        chk("t6_rst_ready", 32'(req_ready_o), 32'd0);
        tick();
        tick();
        rst_i = 1'b1;
        acc_flag = 1'b0;
        n = 0;
        while (!uart_rdy_tx_i && n < 40) begin
            tick();
            n++;
        end
        chk("t6_no_early_ready", 32'(acc_flag), 32'd0);
        chk("t6_rdy_back", 32'(uart_rdy_tx_i), 32'd1);
        wait_accept("t6_after", 4'b1000);
        wait_idle("t6_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
